// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - LSB-first parallel-in/serial-out shifter with valid/ready input
// Outputs decode directly from registered state so an async reset clears them at once.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;

  assign last       = (state == SHIFT) && (cnt == CNT_LAST);
  assign din_ready  = (state == IDLE) || last;
  assign accept     = din_valid && din_ready;
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) && shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      // Also covers the last-bit cycle: reload for zero-gap streaming.
      state <= SHIFT;
      shreg <= din;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      if (last) begin
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed scoreboard bench for piso_serializer
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       last;
  logic [3:0] sipo_q;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;

  piso_serializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving 4-bit sipo: new bit enters at the MSB so q[0] ends as bit0.
  always @(posedge clk) sipo_q <= {sout, sipo_q[3:1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) sb.push_back({w[i], (i == 3) ? 1'b1 : 1'b0});
  endtask

  // One clock; samples on the falling edge and checks against the scoreboard.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_bit", {31'd0, sout_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sout", {31'd0, sout}, {31'd0, e.b});
        chk("last", {31'd0, last}, {31'd0, e.l});
      end
    end else begin
      chk("idle_valid", {31'd0, sout_valid}, 32'd0);
      chk("idle_sout", {31'd0, sout}, 32'd0);
      chk("idle_last", {31'd0, last}, 32'd0);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din        = 4'bxxxx;

    // T1: reset state before any clock edge, X on din while not valid
    #3;
    chk("rst_sout", {31'd0, sout}, 32'd0);
    chk("rst_valid", {31'd0, sout_valid}, 32'd0);
    chk("rst_last", {31'd0, last}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();

    // T2: single word
    din = 4'b1011; din_valid = 1'b1;
    chk("t2_ready_idle", {31'd0, din_ready}, 32'd1);
    push_word(4'b1011);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 0) begin din_valid = 1'b0; din = 4'bxxxx; end
      chk("t2_valid", {31'd0, sout_valid}, 32'd1);
      chk("t2_ready", {31'd0, din_ready}, (i == 3) ? 32'd1 : 32'd0);
    end
    cycle();
    chk("t2_drained", sb.size(), 32'd0);
    chk("t2_idle_ready", {31'd0, din_ready}, 32'd1);

    // T3: back-to-back words held valid
    din = 4'b1011; din_valid = 1'b1;
    push_word(4'b1011);
    push_word(4'b0110);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) din = 4'b0110;
      chk("t3_valid", {31'd0, sout_valid}, 32'd1);
      chk("t3_ready", {31'd0, din_ready}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
      if (i == 4) begin din_valid = 1'b0; din = 4'bxxxx; end
    end
    cycle();
    chk("t3_drained", sb.size(), 32'd0);

    // T4: request while busy is held off until the last bit
    din = 4'b1010; din_valid = 1'b1;
    push_word(4'b1010);
    cycle();
    din_valid = 1'b0; din = 4'bxxxx;
    cycle();
    din = 4'hF; din_valid = 1'b1;
    push_word(4'hF);
    cycle();
    chk("t4_ready_busy", {31'd0, din_ready}, 32'd0);
    cycle();
    chk("t4_ready_last", {31'd0, din_ready}, 32'd1);
    cycle();
    din_valid = 1'b0; din = 4'bxxxx;
    for (int i = 0; i < 4; i++) cycle();
    chk("t4_drained", sb.size(), 32'd0);

    // T5: async abort mid-word, then a clean word
    din = 4'b1001; din_valid = 1'b1;
    push_word(4'b1001);
    cycle();
    din_valid = 1'b0; din = 4'bxxxx;
    cycle();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_sout", {31'd0, sout}, 32'd0);
    chk("t5_valid", {31'd0, sout_valid}, 32'd0);
    chk("t5_last", {31'd0, last}, 32'd0);
    chk("t5_ready", {31'd0, din_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    din = 4'b0011; din_valid = 1'b1;
    push_word(4'b0011);
    cycle();
    din_valid = 1'b0; din = 4'bxxxx;
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_drained", sb.size(), 32'd0);

    // T6: loopback into a sipo
    din = 4'b1101; din_valid = 1'b1;
    push_word(4'b1101);
    cycle();
    din_valid = 1'b0; din = 4'bxxxx;
    cycle();
    cycle();
    cycle();
    chk("t6_last_seen", {31'd0, last}, 32'd1);
    @(posedge clk);
    #1;
    chk("t6_sipo_q", {28'd0, sipo_q}, 32'hD);
    @(negedge clk);
    chk("t6_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
